// File: rtl/sparkle_pkg.sv
// -----------------------------------------------------------------------------
// sparkle_pkg
// Shared definitions for the sparkle sprite address generator:
//   - mode_e       : per-channel animation direction mode
//   - ROW_W/COL_W  : pixel coordinate widths of the VGA scan
//   - hit_ch_w()   : width of an index over n items, never below one bit
// -----------------------------------------------------------------------------
package sparkle_pkg;

  typedef enum logic [1:0] {
    MODE_FWD = 2'd0,
    MODE_REV = 2'd1,
    MODE_PP  = 2'd2,
    MODE_FRZ = 2'd3
  } mode_e;

  localparam int ROW_W = 9;
  localparam int COL_W = 10;

  // Width of an index selecting one of n items (one bit minimum).
  function automatic int hit_ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sparkle_frame_seq.sv
// -----------------------------------------------------------------------------
// sparkle_frame_seq
// Per-channel animation sequencer: a free-running timer 0..PERIOD-1 and a frame
// counter that takes one step whenever the timer wraps. The step direction is
// chosen by mode (forward, reverse, ping-pong, frozen). sync restarts the
// channel (timer 0, frame 0, direction up) and overrides a coincident step.
//
// Optional build macro: SPARKLE_PINGPONG_EN
//   defined   - mode 2 bounces between the end frames using a direction flop
//   undefined - mode 2 behaves exactly like forward; no direction flop exists
//
// Ports:
//   clk    in   pixel clock
//   reset  in   asynchronous active-high reset
//   sync   in   single-cycle animation restart
//   mode   in   [1:0] direction mode (mode_e encoding)
//   frame  out  [FRAME_W-1:0] current animation frame
// -----------------------------------------------------------------------------
module sparkle_frame_seq
  import sparkle_pkg::*;
#(
  parameter int FRAMES  = 4,
  parameter int PERIOD  = 5000,
  parameter int FRAME_W = hit_ch_w(FRAMES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sync,
  input  logic [1:0]         mode,
  output logic [FRAME_W-1:0] frame
);

  localparam int                 TIMER_W = (PERIOD <= 1) ? 1 : $clog2(PERIOD);
  localparam logic [TIMER_W-1:0] T_LAST  = TIMER_W'(PERIOD - 1);
  localparam logic [FRAME_W-1:0] F_LAST  = FRAME_W'(FRAMES - 1);

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [FRAME_W-1:0] fwd_next;
  logic               wrap;
`ifdef SPARKLE_PINGPONG_EN
  logic               dir_q, dir_d;   // 0: counting up, 1: counting down
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    timer_d  = timer_q;
    frame_d  = frame_q;
`ifdef SPARKLE_PINGPONG_EN
    dir_d    = dir_q;
`endif
    wrap     = (timer_q == T_LAST);
    // ">=" rather than "==" keeps a stray out-of-range frame stepping back in.
    fwd_next = (frame_q >= F_LAST) ? '0 : frame_q + 1'b1;

    if (sync) begin
      // sync wins over a coincident wrap: restart, no step.
      timer_d = '0;
      frame_d = '0;
`ifdef SPARKLE_PINGPONG_EN
      dir_d   = 1'b0;
`endif
    end else begin
      timer_d = wrap ? '0 : timer_q + 1'b1;
      if (wrap) begin
        if (FRAMES == 1) begin
          frame_d = '0;
        end else begin
          case (mode_e'(mode))
            MODE_FWD: frame_d = fwd_next;
            MODE_REV: frame_d = (frame_q == '0) ? F_LAST : frame_q - 1'b1;
            MODE_PP: begin
`ifdef SPARKLE_PINGPONG_EN
              // Turn around at each end without repeating the end frame.
              if (!dir_q) begin
                if (frame_q >= F_LAST) begin
                  frame_d = frame_q - 1'b1;
                  dir_d   = 1'b1;
                end else begin
                  frame_d = frame_q + 1'b1;
                end
              end else begin
                if (frame_q == '0) begin
                  frame_d = frame_q + 1'b1;
                  dir_d   = 1'b0;
                end else begin
                  frame_d = frame_q - 1'b1;
                end
              end
`else
              frame_d = fwd_next;
`endif
            end
            default:  frame_d = '0;   // frozen
          endcase
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
      frame_q <= '0;
`ifdef SPARKLE_PINGPONG_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      timer_q <= timer_d;
      frame_q <= frame_d;
`ifdef SPARKLE_PINGPONG_EN
      dir_q   <= dir_d;
`endif
    end
  end

  assign frame = frame_q;

endmodule

// File: rtl/sparkle_array.sv
// -----------------------------------------------------------------------------
// sparkle_array
// Multi-channel animated-sprite address generator for the VGA pixel path.
// N_CH independently placed SIZE x SIZE boxes, each animated by its own
// sparkle_frame_seq. For each pixel the lowest-index enabled box containing it
// wins, and the registered outputs give its sprite-ROM address
//   (row-ch_row)*SIZE + (col-ch_col) + frame*SIZE*SIZE
// Misses give addr=0, hit=0, hit_ch=0. Output latency is one clock.
//
// Optional build macro: SPARKLE_PINGPONG_EN (ping-pong mode 2; see
// sparkle_frame_seq). Without it mode 2 runs forward.
//
// Ports:
//   clk      in   pixel clock
//   reset    in   asynchronous active-high reset
//   row      in   [8:0]  current pixel row
//   col      in   [9:0]  current pixel column
//   ch_en    in   [N_CH-1:0]     per-channel enable
//   ch_row   in   [9*N_CH-1:0]   box top rows, channel i at [9i+8:9i]
//   ch_col   in   [10*N_CH-1:0]  box left columns, channel i at [10i+9:10i]
//   ch_mode  in   [2*N_CH-1:0]   per-channel mode (mode_e encoding)
//   sync     in   single-cycle animation restart for all channels
//   addr     out  [ADDR_W-1:0]   sprite-ROM address
//   hit      out  pixel lies inside an enabled box
//   hit_ch   out  index of the winning channel
// -----------------------------------------------------------------------------
module sparkle_array
  import sparkle_pkg::*;
#(
  parameter int N_CH   = 8,
  parameter int SIZE   = 20,
  parameter int FRAMES = 4,
  parameter int PERIOD = 5000,
  parameter int ADDR_W = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ROW_W-1:0]            row,
  input  logic [COL_W-1:0]            col,
  input  logic [N_CH-1:0]             ch_en,
  input  logic [ROW_W*N_CH-1:0]       ch_row,
  input  logic [COL_W*N_CH-1:0]       ch_col,
  input  logic [2*N_CH-1:0]           ch_mode,
  input  logic                        sync,
  output logic [ADDR_W-1:0]           addr,
  output logic                        hit,
  output logic [hit_ch_w(N_CH)-1:0]   hit_ch
);

  localparam int CH_W    = hit_ch_w(N_CH);
  localparam int FRAME_W = hit_ch_w(FRAMES);

  logic [FRAME_W-1:0] frame     [N_CH];
  logic [ROW_W-1:0]   box_row   [N_CH];
  logic [COL_W-1:0]   box_col   [N_CH];
  logic [N_CH-1:0]    ch_hit;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    // Bound sums are one bit wider than the coordinate so a box hanging off
    // the bottom/right edge never wraps back onto row/column 0.
    logic [ROW_W:0] row_end;
    logic [COL_W:0] col_end;

    sparkle_frame_seq #(
      .FRAMES  (FRAMES),
      .PERIOD  (PERIOD),
      .FRAME_W (FRAME_W)
    ) u_seq (
      .clk   (clk),
      .reset (reset),
      .sync  (sync),
      .mode  (ch_mode[2*g +: 2]),
      .frame (frame[g])
    );

    assign box_row[g] = ch_row[ROW_W*g +: ROW_W];
    assign box_col[g] = ch_col[COL_W*g +: COL_W];
    assign row_end    = {1'b0, box_row[g]} + (ROW_W+1)'(SIZE);
    assign col_end    = {1'b0, box_col[g]} + (COL_W+1)'(SIZE);
    assign ch_hit[g]  = ch_en[g]
                      && (row >= box_row[g]) && ({1'b0, row} < row_end)
                      && (col >= box_col[g]) && ({1'b0, col} < col_end);
  end

  logic                hit_d,    hit_q;
  logic [CH_W-1:0]     hit_ch_d, hit_ch_q;
  logic [ADDR_W-1:0]   addr_d,   addr_q;
  logic [ROW_W-1:0]    sel_row, d_row;
  logic [COL_W-1:0]    sel_col, d_col;
  logic [FRAME_W-1:0]  sel_frame;

  // Lowest-index priority: scan from the top down so lower channels overwrite.
  // Only the winner's geometry feeds the single multiply-add below.
  always_comb begin
    hit_d     = 1'b0;
    hit_ch_d  = '0;
    sel_row   = '0;
    sel_col   = '0;
    sel_frame = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_hit[i]) begin
        hit_d     = 1'b1;
        hit_ch_d  = CH_W'(i);
        sel_row   = box_row[i];
        sel_col   = box_col[i];
        sel_frame = frame[i];
      end
    end

    d_row  = row - sel_row;
    d_col  = col - sel_col;
    addr_d = '0;
    if (hit_d) begin
      addr_d = ADDR_W'(int'(d_row) * SIZE + int'(d_col)
                       + int'(sel_frame) * SIZE * SIZE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q    <= 1'b0;
      hit_ch_q <= '0;
      addr_q   <= '0;
    end else begin
      hit_q    <= hit_d;
      hit_ch_q <= hit_ch_d;
      addr_q   <= addr_d;
    end
  end

  assign hit    = hit_q;
  assign hit_ch = hit_ch_q;
  assign addr   = addr_q;

endmodule

// File: tb/tb_sparkle_array.sv
// -----------------------------------------------------------------------------
// tb_sparkle_array
// Self-checking bench for sparkle_array. A behavioural model tracks each
// channel's timer/frame with plain integer arithmetic and derives the expected
// registered outputs from the box geometry. Directed scenarios (reset, mode
// sequences, overlap priority, screen edge, sync at wrap) are followed by
// randomized stimulus.
// -----------------------------------------------------------------------------
module tb_sparkle_array;
  import sparkle_pkg::*;

  localparam int N_CH   = 5;
  localparam int SIZE   = 20;
  localparam int FRAMES = 4;
  localparam int PERIOD = 4;
  localparam int ADDR_W = 12;
  localparam int CH_W   = hit_ch_w(N_CH);

  logic                  clk = 1'b0;
  logic                  reset;
  logic [ROW_W-1:0]      row;
  logic [COL_W-1:0]      col;
  logic [N_CH-1:0]       ch_en;
  logic [ROW_W*N_CH-1:0] ch_row;
  logic [COL_W*N_CH-1:0] ch_col;
  logic [2*N_CH-1:0]     ch_mode;
  logic                  sync;
  logic [ADDR_W-1:0]     addr;
  logic                  hit;
  logic [CH_W-1:0]       hit_ch;

  sparkle_array #(
    .N_CH(N_CH), .SIZE(SIZE), .FRAMES(FRAMES), .PERIOD(PERIOD), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .row(row), .col(col), .ch_en(ch_en),
    .ch_row(ch_row), .ch_col(ch_col), .ch_mode(ch_mode), .sync(sync),
    .addr(addr), .hit(hit), .hit_ch(hit_ch)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: per-channel timer, frame and ping-pong direction.
  int m_timer [N_CH];
  int m_frame [N_CH];
  bit m_down  [N_CH];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_timer[i] = 0;
      m_frame[i] = 0;
      m_down[i]  = 1'b0;
    end
  endfunction

  function automatic int next_frame(input int i);
    int f;
    int m;
    f = m_frame[i];
    m = int'(ch_mode[2*i +: 2]);
    if (FRAMES == 1) return 0;
`ifndef SPARKLE_PINGPONG_EN
    if (m == 2) m = 0;
`endif
    case (m)
      0: return (f + 1) % FRAMES;
      1: return (f + FRAMES - 1) % FRAMES;
      2: begin
        if (!m_down[i]) begin
          if (f + 1 < FRAMES) return f + 1;
          m_down[i] = 1'b1;
          return f - 1;
        end
        if (f > 0) return f - 1;
        m_down[i] = 1'b0;
        return f + 1;
      end
      default: return 0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs seen at that edge.
  function automatic void model_edge();
    for (int i = 0; i < N_CH; i++) begin
      if (sync) begin
        m_timer[i] = 0;
        m_frame[i] = 0;
        m_down[i]  = 1'b0;
      end else if (m_timer[i] == PERIOD - 1) begin
        m_timer[i] = 0;
        m_frame[i] = next_frame(i);
      end else begin
        m_timer[i]++;
      end
    end
  endfunction

  function automatic void expected(output logic e_hit, output int e_ch,
                                   output int e_addr);
    int r;
    int c;
    int r0;
    int c0;
    e_hit  = 1'b0;
    e_ch   = 0;
    e_addr = 0;
    r = int'(row);
    c = int'(col);
    for (int i = 0; i < N_CH; i++) begin
      r0 = int'(ch_row[ROW_W*i +: ROW_W]);
      c0 = int'(ch_col[COL_W*i +: COL_W]);
      if (!e_hit && ch_en[i] && r >= r0 && r < r0 + SIZE && c >= c0 && c < c0 + SIZE) begin
        e_hit  = 1'b1;
        e_ch   = i;
        e_addr = ((r - r0) * SIZE + (c - c0) + m_frame[i] * SIZE * SIZE) % (1 << ADDR_W);
      end
    end
  endfunction

  // One clock: compute expectation from pre-edge state, clock, check at +1.
  task automatic tick(input string tag);
    logic e_hit;
    int   e_ch;
    int   e_addr;
    expected(e_hit, e_ch, e_addr);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, "_hit"},  32'(hit),    32'(e_hit));
    check({tag, "_ch"},   32'(hit_ch), 32'(e_ch));
    check({tag, "_addr"}, 32'(addr),   32'(e_addr));
  endtask

  task automatic set_ch(input int i, input int r, input int c, input bit en,
                        input int mode);
    ch_row[ROW_W*i +: ROW_W] = ROW_W'(r);
    ch_col[COL_W*i +: COL_W] = COL_W'(c);
    ch_en[i]                 = en;
    ch_mode[2*i +: 2]        = 2'(mode);
  endtask

  task automatic set_pix(input int r, input int c);
    row = ROW_W'(r);
    col = COL_W'(c);
  endtask

  initial begin
    bit reached;
    reset   = 1'b1;
    sync    = 1'b0;
    row     = '0;
    col     = '0;
    ch_en   = '0;
    ch_row  = '0;
    ch_col  = '0;
    ch_mode = '0;
    model_reset();

    // Reset state with a pixel that would otherwise hit.
    set_ch(0, 100, 100, 1'b1, 0);
    set_pix(105, 105);
    #12;
    check("rst_hit",  32'(hit),    32'd0);
    check("rst_ch",   32'(hit_ch), 32'd0);
    check("rst_addr", 32'(addr),   32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Forward (ch0), ping-pong (ch1) and reverse (ch2) sequences; the pixel
    // rotates between the three boxes so every channel's frame is observed.
    set_ch(0, 100, 100, 1'b1, 0);
    set_ch(1, 200, 200, 1'b1, 2);
    set_ch(2, 300, 300, 1'b1, 1);
    for (int n = 0; n < 48; n++) begin
      case (n % 3)
        0:       set_pix(101, 102);   // offset 22 within ch0
        1:       set_pix(219, 219);
        default: set_pix(300, 301);
      endcase
      tick("seq");
    end

    // Mid-animation asynchronous reset, released between edges.
    #3 reset = 1'b1;
    #1;
    check("mid_rst_hit",  32'(hit),    32'd0);
    check("mid_rst_ch",   32'(hit_ch), 32'd0);
    check("mid_rst_addr", 32'(addr),   32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    set_pix(100, 100);
    for (int n = 0; n < 2 * PERIOD + 2; n++) tick("post_rst");

    // Overlap priority: lowest index wins, then ch0 disabled.
    ch_en = '0;
    set_ch(0, 100, 100, 1'b1, 0);
    set_ch(3, 110, 110, 1'b1, 0);
    set_pix(115, 115);
    tick("ovl_both");
    tick("ovl_both2");
    ch_en[0] = 1'b0;
    tick("ovl_ch3");
    set_pix(109, 129);
    tick("ovl_gap");

    // Screen-edge box: bottom-right corner hits, (0,0) and just outside miss.
    ch_en = '0;
    set_ch(4, 470, 630, 1'b1, 3);
    set_pix(479, 639);
    tick("edge_in");
    set_pix(0, 0);
    tick("edge_zero");
    set_pix(489, 649);
    tick("edge_last");
    set_pix(490, 649);
    tick("edge_row_out");
    set_pix(489, 650);
    tick("edge_col_out");

    // sync exactly on the wrap edge of a reverse channel sitting on frame 2.
    ch_en = '0;
    set_ch(0, 100, 100, 1'b1, 1);
    set_pix(100, 100);
    sync = 1'b1;
    tick("sync_align");
    sync = 1'b0;
    reached = 1'b0;
    for (int n = 0; n < 64 && !reached; n++) begin
      tick("rev_walk");
      reached = (m_frame[0] == 2) && (m_timer[0] == PERIOD - 1);
    end
    check("rev_reach", 32'(reached), 32'd1);
    sync = 1'b1;
    tick("sync_wrap");
    sync = 1'b0;
    tick("after_sync");
    check("after_sync_frame0", 32'(addr), 32'd0);
    for (int n = 0; n < PERIOD + 2; n++) tick("rev_restart");

    // Randomized traffic, boxes mostly placed near the pixel to get hits.
    for (int n = 0; n < 800; n++) begin
      set_pix(int'($urandom_range(0, 479)), int'($urandom_range(0, 639)));
      for (int i = 0; i < N_CH; i++) begin
        int r;
        int c;
        if ($urandom_range(0, 3) != 0) begin
          r = int'(row) - int'($urandom_range(0, 24));
          c = int'(col) - int'($urandom_range(0, 24));
          if (r < 0) r = 0;
          if (c < 0) c = 0;
        end else begin
          r = int'($urandom_range(0, 479));
          c = int'($urandom_range(0, 639));
        end
        ch_row[ROW_W*i +: ROW_W] = ROW_W'(r);
        ch_col[COL_W*i +: COL_W] = COL_W'(c);
        ch_en[i] = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 15) == 0) ch_mode[2*i +: 2] = 2'($urandom_range(0, 3));
      end
      sync = ($urandom_range(0, 39) == 0);
      tick("rand");
    end
    sync = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
